// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: loads a seed serially into an external 2-flop XOR shift register, runs it and
// returns OUT_W collected feedback bits. Optional macro LFSR_SEQ_ZSEED_EN maps an all-zero seed to 1.
//
// Handshakes (cmd_* and res_*): a transfer happens on a rising clk edge where valid and ready are
// both 1; the producer holds valid and its payload until that edge, and ready never depends on valid.
module lfsr_seq_ctrl #(
  parameter int SEED_W = 2,
  parameter int OUT_W  = 8,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEED_W-1:0] cmd_seed,
  input  logic              abort,
  output logic              lfsr_ena,
  output logic              lfsr_seed,
  input  logic              lfsr_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = $clog2(LAT + OUT_W + 1);
  localparam logic [CNT_W-1:0] LOAD_LEN    = CNT_W'(SEED_W);
  localparam logic [CNT_W-1:0] RUN_LEN     = CNT_W'(LAT + OUT_W);
  localparam logic [CNT_W-1:0] COLLECT_LEN = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SEED_W-1:0]   seed_sr;
  logic [SEED_W-1:0]   start_seed;

`ifdef LFSR_SEQ_ZSEED_EN
  assign start_seed = (cmd_seed == '0) ? SEED_W'(1) : cmd_seed;
`else
  assign start_seed = cmd_seed;
`endif

  // seed_sr drains to zero by the end of LOAD and is cleared on abort, so its bit 0 is the
  // seed line in every state.
  assign lfsr_seed = seed_sr[0];
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      seed_sr   <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      lfsr_ena  <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            seed_sr   <= start_seed;
            cnt       <= LOAD_LEN;
            cmd_ready <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            seed_sr   <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            seed_sr <= seed_sr >> 1;
            if (cnt == CNT_ONE) begin
              cnt      <= RUN_LEN;
              lfsr_ena <= 1'b1;
              state    <= RUN;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            cnt       <= '0;
            lfsr_ena  <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            // The last OUT_W RUN cycles carry valid feedback; shifting right leaves the first at bit 0.
            if (cnt <= COLLECT_LEN) begin
              res_data <= {lfsr_out, res_data[OUT_W-1:1]};
            end
            if (cnt == CNT_ONE) begin
              cnt       <= '0;
              lfsr_ena  <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencer for the 2-flop XOR-feedback shift register (ports `ena`, `seed`, `out`) used in the pseudo-random stimulus path. It accepts a seed and a run request over a valid/ready handshake and loads the seed serially with `ena=0`. It then runs the register with `ena=1`, gathers `OUT_W` feedback bits from `out` into a word, and returns that word over a second valid/ready handshake. The block drives the shift register's `ena`/`seed` inputs and samples its `out`; it contains no LFSR state itself.

## Interface
- `SEED_W`, 2: seed bits shifted in per command; must be >= 2 (register depth).
- `OUT_W`, 8: result bits collected per command.
- `LAT`, 3: cycles from driving `lfsr_ena`/`lfsr_seed` to the matching value on `lfsr_out`.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at an edge.
- `cmd_seed`  in  SEED_W  seed, shifted LSB first.
- `abort`  in  1  synchronous cancel of an in-flight command.
- `lfsr_ena`  out  1  to shift register `ena`.
- `lfsr_seed`  out  1  to shift register `seed`.
- `lfsr_out`  in  1  from shift register `out`.
- `res_valid`  out  1  result word available.
- `res_ready`  in  1  consumer takes the result when `res_valid & res_ready` at an edge.
- `res_data`  out  OUT_W  collected bits; bit 0 is the first collected.

## Operation
- States: IDLE, LOAD, RUN, DONE. A down-counter of width clog2(LAT+OUT_W+1) tracks the cycles remaining in the current state.
- IDLE:
  - `cmd_ready=1`, `lfsr_ena=0`, `lfsr_seed=0`.
  - On accept: latch `cmd_seed` into a shift register, load the counter with SEED_W, go to LOAD.
- LOAD:
  - `lfsr_ena=0`, `lfsr_seed` = seed shift register bit 0. The shift register shifts right each cycle.
  - After SEED_W cycles, load the counter with LAT+OUT_W and go to RUN.
- RUN:
  - `lfsr_ena=1`, `lfsr_seed=0`. RUN cycles are numbered 1..LAT+OUT_W.
  - In RUN cycle LAT+1+i, `lfsr_out` is sampled into `res_data[i]` for i = 0..OUT_W-1.
  - After the last RUN cycle, go to DONE.
- DONE:
  - `res_valid=1`, `lfsr_ena=0`, `lfsr_seed=0`.
  - `res_data` is held stable until the handshake, then the block returns to IDLE.
  - `res_data` keeps its value in IDLE until the next collection overwrites it.
- `abort` high at an edge in LOAD or RUN: go to IDLE, no result produced, `res_data` contents undefined-but-stable.
  - `abort` is ignored in IDLE and DONE.
  - `abort` and `cmd_valid` together in IDLE: the command is accepted.
- `cmd_ready` is 0 in LOAD, RUN and DONE. Commands presented in those states wait and are not dropped.
- Reset (any state, asynchronous):
  - State = IDLE, counter = 0, seed shift register = 0, `res_data=0`.
  - Outputs: `res_valid=0`, `lfsr_ena=0`, `lfsr_seed=0`, `cmd_ready=1`.
  - Reset mid-LOAD/RUN discards the command. The shift register is not reset by this block.

## Timing
- All outputs are Moore functions of registered state. There are no combinational paths from any input to any output.
- Accept edge = E0. `res_valid` rises after edge E0+SEED_W+LAT+OUT_W. Defaults: 13 edges.
- Back-to-back commands: with `res_ready` held high, the minimum command period is SEED_W+LAT+OUT_W+2 cycles (one DONE cycle plus one IDLE cycle).
- `res_ready` held low stalls in DONE indefinitely. `res_data` and `res_valid` do not change during the stall.

## Configuration
- `LFSR_SEQ_ZSEED_EN` defined: an all-zero `cmd_seed` is replaced at accept by a value with only bit 0 set. This avoids the XOR lock-up state. Nonzero seeds are unaffected.
- Not defined: the seed is loaded as given. A zero seed yields `res_data=0`.

## Test plan
Defaults, block connected to the real shift register.
- Reset released, `cmd_seed=2'b01` accepted -> `res_valid` rises 13 edges later with `res_data=8'hDB`. `lfsr_ena` is 0 for 2 cycles, then 1 for 11 cycles.
- Seeds `2'b11` and `2'b10` back-to-back, `res_ready=1` -> results `8'hB6` then `8'h6D`. Second accept occurs 2 cycles after the first `res_valid`.
- `cmd_seed=2'b00` -> `8'h00` without the macro, `8'hDB` with `LFSR_SEQ_ZSEED_EN`.
- `res_ready=0` for 20 cycles in DONE -> `res_valid` and `res_data` stable, `cmd_ready=0` throughout. `res_ready=1` -> IDLE next cycle.
- `abort` in RUN cycle 5 -> IDLE next cycle, no `res_valid`. A following seed `2'b01` -> `8'hDB`.
- `rst` asserted mid-LOAD -> outputs take reset values immediately without waiting for a clock edge. After release, a new command completes normally.
